// File: rtl/axis_rr_arbiter_pkg.sv
// Shared AXI-Stream definitions for the round-robin arbiter slice.
//
// Contents:
//   - default stream widths used as parameter defaults by the stream blocks
//   - burst counter width (large enough for bursts of up to 255 beats)
//   - arbiter FSM state encoding
//   - idx_width(): width of an index able to address n inputs
package axis_rr_arbiter_pkg;

  localparam int AXIS_DATA_WIDTH_DEFAULT = 8;
  localparam int AXIS_USER_WIDTH_DEFAULT = 4;
  localparam int AXIS_NUM_INPUTS_DEFAULT = 4;

  // Burst counter width; covers BURST_LEN up to 255.
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,  // no input owns the output, arbitration happens here
    ST_GRANT = 1'b1   // one input owns the output until its burst ends
  } arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority search.
//
// Finds the first asserted request starting at (last + 1) mod NUM_INPUTS and
// wrapping around, so the input at 'last' is considered last of all.
// Purely combinational.
//
// Ports:
//   req    in   NUM_INPUTS bits  request vector
//   last   in   IDX_W bits       index that was served most recently
//   found  out  1 bit            at least one request is asserted
//   index  out  IDX_W bits       selected input (0 when found = 0)
import axis_rr_arbiter_pkg::*;

module rr_priority_pick #(
  parameter int NUM_INPUTS = AXIS_NUM_INPUTS_DEFAULT,
  parameter int IDX_W      = idx_width(NUM_INPUTS)
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]      last,
  output logic                  found,
  output logic [IDX_W-1:0]      index
);

  always_comb begin
    int cand;
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      cand = int'(last) + k;
      if (cand >= NUM_INPUTS) begin
        cand = cand - NUM_INPUTS;
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// AXI-Stream round-robin arbiter with burst-limited grants.
//
// Merges NUM_INPUTS slave streams onto one master stream. An input keeps the
// output for up to BURST_LEN accepted beats, or until it stops offering data
// while it could be accepted. Arbitration takes one IDLE cycle; the search
// starts just after the previously served input. The output is a single
// copy register: one beat of latency, m_tuser carries the source index.
//
// FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no grant, s_tready all zero, round-robin search this cycle
//   ST_GRANT | input 'grant' may push beats while the output has room
//
// Ports:
//   clock     in   1 bit                    rising-edge clock
//   reset     in   1 bit                    asynchronous, active-high
//   s_tdata   in   NUM_INPUTS*DATA_WIDTH    input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_tvalid  in   NUM_INPUTS               per-input valid
//   s_tready  out  NUM_INPUTS               per-input ready (granted input only)
//   m_tdata   out  DATA_WIDTH               registered beat
//   m_tuser   out  USER_WIDTH               source index of m_tdata
//   m_tvalid  out  1 bit                    output valid
//   m_tready  in   1 bit                    output ready
import axis_rr_arbiter_pkg::*;

module axis_rr_arbiter #(
  parameter int DATA_WIDTH = AXIS_DATA_WIDTH_DEFAULT,
  parameter int NUM_INPUTS = AXIS_NUM_INPUTS_DEFAULT,
  parameter int USER_WIDTH = AXIS_USER_WIDTH_DEFAULT,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_INPUTS-1:0]            s_tvalid,
  output logic [NUM_INPUTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]            m_tdata,
  output logic [USER_WIDTH-1:0]            m_tuser,
  output logic                             m_tvalid,
  input  logic                             m_tready
);

  localparam int IDX_W = idx_width(NUM_INPUTS);
  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_INIT  = IDX_W'(NUM_INPUTS - 1);

  arb_state_t state, state_next;

  logic [IDX_W-1:0] grant, grant_next;
  logic [IDX_W-1:0] last_grant, last_grant_next;
  logic [CNT_W-1:0] count, count_next;

  logic             pick_found;
  logic [IDX_W-1:0] pick_index;

  logic [DATA_WIDTH-1:0] lane [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] sel_data;

  logic out_room;
  logic accept;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    assign lane[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign sel_data = lane[grant];

  // The copy register can take a new beat when empty or draining this cycle.
  assign out_room = !m_tvalid || m_tready;

  rr_priority_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_pick (
    .req   (s_tvalid),
    .last  (last_grant),
    .found (pick_found),
    .index (pick_index)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= LAST_INIT;
      count      <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      count      <= count_next;
    end
  end

  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    count_next      = count;
    s_tready        = '0;
    accept          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_next = ST_GRANT;
          grant_next = pick_index;
          count_next = '0;
        end
      end
      ST_GRANT: begin
        s_tready[grant] = out_room;
        // Back-pressure (out_room = 0) freezes both grant and count.
        if (out_room) begin
          if (s_tvalid[grant]) begin
            accept     = 1'b1;
            count_next = count + 1'b1;
            if (count == BURST_LAST) begin
              state_next      = ST_IDLE;
              last_grant_next = grant;
            end
          end else begin
            // Granted input went quiet while it could have sent: give up.
            state_next      = ST_IDLE;
            last_grant_next = grant;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Single-stage copy register on the master side.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_tdata  <= '0;
      m_tuser  <= '0;
      m_tvalid <= 1'b0;
    end else if (accept) begin
      m_tdata  <= sel_data;
      m_tuser  <= USER_WIDTH'(grant);
      m_tvalid <= 1'b1;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

  localparam int DW = 8;
  localparam int NI = 4;
  localparam int UW = 4;
  localparam int BL = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NI*DW-1:0]  s_tdata = '0;
  logic [NI-1:0]     s_tvalid = '0;
  logic [NI-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [UW-1:0]     m_tuser;
  logic              m_tvalid;
  logic              m_tready = 1'b1;

  typedef struct packed {
    logic [UW-1:0] user;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Source model: input i offers base[i] + sq[i], sq counts its accepted beats.
  int sq[NI];
  int base[NI];
  logic [NI-1:0] acc;

  axis_rr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI),
    .USER_WIDTH (UW),
    .BURST_LEN  (BL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .m_tdata  (m_tdata),
    .m_tuser  (m_tuser),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < NI; i++) begin
      s_tdata[i*DW +: DW] = DW'(base[i] + sq[i]);
    end
  endfunction

  function automatic void push(input int user, input int data);
    beat_t b;
    b.user = UW'(user);
    b.data = DW'(data);
    exp_q.push_back(b);
  endfunction

  // One clock: handshakes are sampled on the falling edge, inputs updated 1ns after the rising edge.
  task automatic tick();
    @(negedge clock);
    acc = s_tvalid & s_tready;
    @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (acc[i]) sq[i]++;
    end
    refresh();
  endtask

  task automatic wait_sq(input int idx, input int target, input int limit, input string name);
    int n;
    n = 0;
    while (sq[idx] < target && n < limit) begin
      tick();
      n++;
    end
    check(name, 32'(sq[idx]), 32'(target));
  endtask

  task automatic drain(input string name);
    repeat (3) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    s_tvalid = '0;
    m_tready = 1'b1;
    for (int i = 0; i < NI; i++) begin
      sq[i]   = 0;
      base[i] = i * 16;
    end
    refresh();
    tick();
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_m_tuser", 32'(m_tuser), 32'd0);
    tick();
    reset = 1'b0;
    check("post_rst_s_tready", 32'(s_tready), 32'd0);
  endtask

  // Monitor: pops one expected beat per output transfer.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && m_tvalid && m_tready) begin
        beat_t e;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got user %0d data %0h expected no beat", m_tuser, m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tuser !== e.user || m_tdata !== e.data) begin
            errors++;
            $display("FAIL beat: got user %0d data %0h expected user %0d data %0h",
                     m_tuser, m_tdata, e.user, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // All inputs valid: 4-beat bursts in order 0,1,2,3 with one bubble between grants.
    do_reset();
    s_tvalid = 4'b1111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NI; i++)
        for (int b = 0; b < 4; b++)
          push(i, i * 16 + r * 4 + b);
    tick();
    check("arb_grant0_ready", 32'(s_tready), 32'b0001);
    check("arb_no_out_yet", 32'(m_tvalid), 32'd0);
    tick();
    check("first_beat_valid", 32'(m_tvalid), 32'd1);
    check("first_beat_user", 32'(m_tuser), 32'd0);
    tick();
    tick();
    tick();
    check("bubble_s_tready", 32'(s_tready), 32'd0);
    tick();
    check("bubble_m_tvalid", 32'(m_tvalid), 32'd0);
    check("grant1_ready", 32'(s_tready), 32'b0010);
    wait_sq(3, 8, 80, "rr_input3_beats");
    s_tvalid = '0;
    drain("rr_queue_empty");
    for (int i = 0; i < NI; i++) check("rr_equal_share", 32'(sq[i]), 32'd8);

    // Single beat from input 2, next search begins at input 3.
    do_reset();
    base[2] = 8'hA5;
    refresh();
    push(2, 8'hA5);
    s_tvalid = 4'b0100;
    tick();
    tick();
    s_tvalid = 4'b1001;
    tick();
    check("idle_release_ready", 32'(s_tready), 32'd0);
    tick();
    check("search_from_3", 32'(s_tready), 32'b1000);
    s_tvalid = '0;
    tick();
    drain("single_queue_empty");

    // Back-pressure during a burst from input 1.
    do_reset();
    s_tvalid = 4'b0010;
    for (int b = 0; b < 4; b++) push(1, 16 + b);
    tick();
    tick();
    tick();
    m_tready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("hold_m_tdata", 32'(m_tdata), 32'h11);
      check("hold_m_tuser", 32'(m_tuser), 32'd1);
      check("hold_s_tready", 32'(s_tready), 32'd0);
    end
    m_tready = 1'b1;
    tick();
    check("resume_still_granted", 32'(s_tready), 32'b0010);
    tick();
    check("resume_released", 32'(s_tready), 32'd0);
    s_tvalid = '0;
    check("bp_accepts", 32'(sq[1]), 32'd4);
    drain("bp_queue_empty");

    // Input 3 goes quiet after 2 beats while input 0 waits.
    do_reset();
    s_tvalid = 4'b1000;
    push(3, 8'h30);
    push(3, 8'h31);
    for (int b = 0; b < 4; b++) push(0, b);
    tick();
    check("grant3_ready", 32'(s_tready), 32'b1000);
    s_tvalid = 4'b1001;
    tick();
    tick();
    s_tvalid = 4'b0001;
    tick();
    check("drop_release", 32'(s_tready), 32'd0);
    s_tvalid = 4'b1001;
    tick();
    check("fair_grant0", 32'(s_tready), 32'b0001);
    wait_sq(0, 4, 10, "fair_input0_beats");
    s_tvalid = '0;
    check("input3_beats", 32'(sq[3]), 32'd2);
    drain("fair_queue_empty");

    // Asynchronous reset with a beat pending on the output.
    do_reset();
    s_tvalid = 4'b0100;
    tick();
    tick();
    m_tready = 1'b0;
    check("pending_valid", 32'(m_tvalid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_m_tvalid", 32'(m_tvalid), 32'd0);
    check("async_m_tdata", 32'(m_tdata), 32'd0);
    check("async_s_tready", 32'(s_tready), 32'd0);
    tick();
    s_tvalid = 4'b0101;
    m_tready = 1'b1;
    for (int i = 0; i < NI; i++) sq[i] = 0;
    refresh();
    reset = 1'b0;
    check("rerst_s_tready", 32'(s_tready), 32'd0);
    for (int b = 0; b < 4; b++) push(0, b);
    tick();
    check("restart_grant0", 32'(s_tready), 32'b0001);
    wait_sq(0, 4, 10, "restart_beats");
    s_tvalid = '0;
    drain("restart_queue_empty");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
